// File: rtl/address_creator.sv
// Purpose : steps a registered address by STEP on each rising edge of the asynchronous done input, wrapping inside [START_ADDR, END_ADDR].
// Latency : done first sampled high at edge k -> address updates after edge k+SYNC_STAGES; wrap pulses in that same cycle.
// Backpressure: none; done pulses shorter than 2 clocks high or 2 clocks low may be lost, which is harmless.
module address_creator #(
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] END_ADDR    = '1,   // inclusive, must be >= START_ADDR
    parameter logic [ADDR_WIDTH-1:0] STEP        = 1,    // must be >= 1
    parameter int unsigned           SYNC_STAGES = 2     // must be >= 2
) (
    input  logic                  clock,
    input  logic                  reset,   // synchronous, active-low
    input  logic                  done,    // asynchronous level from upstream
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  wrap
);

    // Synchroniser chain; bit 0 is the metastability-catching flop, the MSB is done_s.
    logic [SYNC_STAGES-1:0] sync_r;
    // done_s delayed by one clock, for rising-edge detection.
    logic                   done_q;
    logic                   done_s;
    logic                   rise;

    // One bit wider than the address so address + STEP can never silently overflow.
    logic [ADDR_WIDTH:0]    next_addr;
    logic                   past_end;

    assign done_s    = sync_r[SYNC_STAGES-1];
    assign rise      = done_s & ~done_q;
    assign next_addr = {1'b0, address} + {1'b0, STEP};
    assign past_end  = (next_addr > {1'b0, END_ADDR});

    // Synchronise done and keep a one-cycle history; reset flushes any edge in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_r <= '0;
            done_q <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], done};
            done_q <= done_s;
        end
    end

    // Advance the address once per synchronised done rise, wrapping past END_ADDR.
    always_ff @(posedge clock) begin
        if (!reset) begin
            address <= START_ADDR;
            wrap    <= 1'b0;
        end else if (rise) begin
            if (past_end) begin
                address <= START_ADDR;
                wrap    <= 1'b1;
            end else begin
                address <= next_addr[ADDR_WIDTH-1:0];
                wrap    <= 1'b0;
            end
        end else begin
            wrap    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_address_creator.sv
// Purpose : directed checks of address_creator in four parameterisations sharing one done input.
// Latency : each advance is checked at the exact edge k+2 after done is first sampled.
// Backpressure: not applicable; the bench drives done with fixed cycle counts only.
module tb_address_creator;

    logic clock = 1'b0;
    logic reset;
    logic done;

    always #5 clock = ~clock;

    logic [15:0] a_def, a_win, a_big, a_deg;
    logic        w_def, w_win, w_big, w_deg;

    int n_cmp = 0;
    int n_err = 0;

    // Previously expected addresses, used to verify that nothing moves early.
    logic [15:0] p_def, p_win, p_big;

    // Defaults: 0..FFFF, step 1.
    address_creator u_def (
        .clock(clock), .reset(reset), .done(done), .address(a_def), .wrap(w_def)
    );

    // Custom window 0x10..0x15, step 2 (non-aligned: 0x16 is past the end).
    address_creator #(.START_ADDR(16'h0010), .END_ADDR(16'h0015), .STEP(16'h0002)) u_win (
        .clock(clock), .reset(reset), .done(done), .address(a_win), .wrap(w_win)
    );

    // Full window with a large step: 0, 5555, AAAA, FFFF, then wraps to 0000.
    address_creator #(.STEP(16'h5555)) u_big (
        .clock(clock), .reset(reset), .done(done), .address(a_big), .wrap(w_big)
    );

    // Degenerate window: every advance wraps.
    address_creator #(.START_ADDR(16'h0007), .END_ADDR(16'h0007)) u_deg (
        .clock(clock), .reset(reset), .done(done), .address(a_deg), .wrap(w_deg)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag,
                             input logic [15:0] e_def,
                             input logic [15:0] e_win, input logic e_winw,
                             input logic [15:0] e_big, input logic e_bigw,
                             input logic e_degw);
        chk({tag, ".def_addr"}, a_def, e_def);
        chk({tag, ".def_wrap"}, {15'd0, w_def}, 16'd0);
        chk({tag, ".win_addr"}, a_win, e_win);
        chk({tag, ".win_wrap"}, {15'd0, w_win}, {15'd0, e_winw});
        chk({tag, ".big_addr"}, a_big, e_big);
        chk({tag, ".big_wrap"}, {15'd0, w_big}, {15'd0, e_bigw});
        chk({tag, ".deg_addr"}, a_deg, 16'h0007);
        chk({tag, ".deg_wrap"}, {15'd0, w_deg}, {15'd0, e_degw});
    endtask

    // One done pulse with exact latency check: edges k and k+1 hold, k+2 advances, k+3 drops wrap.
    task automatic adv(input string tag,
                       input logic [15:0] e_def,
                       input logic [15:0] e_win, input logic e_winw,
                       input logic [15:0] e_big, input logic e_bigw);
        @(negedge clock);
        done = 1'b1;
        @(posedge clock); #1;
        chk_state({tag, ".k0"}, p_def, p_win, 1'b0, p_big, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk_state({tag, ".k1"}, p_def, p_win, 1'b0, p_big, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk_state({tag, ".k2"}, e_def, e_win, e_winw, e_big, e_bigw, 1'b1);
        @(posedge clock); #1;
        chk_state({tag, ".k3"}, e_def, e_win, 1'b0, e_big, 1'b0, 1'b0);
        @(negedge clock);
        done = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk_state({tag, ".fall"}, e_def, e_win, 1'b0, e_big, 1'b0, 1'b0);
        p_def = e_def;
        p_win = e_win;
        p_big = e_big;
    endtask

    initial begin
        reset = 1'b0;
        done  = 1'b0;
        p_def = 16'h0000;
        p_win = 16'h0010;
        p_big = 16'h0000;

        // Reset held for 3 clocks while done toggles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            done = ~done;
            @(posedge clock); #1;
            chk_state("reset", 16'h0000, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);
        end
        @(negedge clock);
        done  = 1'b0;
        reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        chk_state("post_reset", 16'h0000, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Basic advances, window wrap and 16-bit overflow wrap.
        adv("p1", 16'h0001, 16'h0012, 1'b0, 16'h5555, 1'b0);
        adv("p2", 16'h0002, 16'h0014, 1'b0, 16'hAAAA, 1'b0);
        adv("p3", 16'h0003, 16'h0010, 1'b1, 16'hFFFF, 1'b0);
        adv("p4", 16'h0004, 16'h0012, 1'b0, 16'h0000, 1'b1);

        // Level hold: 20 clocks high gives exactly one advance.
        @(negedge clock);
        done = 1'b1;
        repeat (20) @(negedge clock);
        done = 1'b0;
        chk_state("level_hold", 16'h0005, 16'h0014, 1'b0, 16'h5555, 1'b0, 1'b0);
        repeat (5) @(negedge clock);
        chk_state("level_low", 16'h0005, 16'h0014, 1'b0, 16'h5555, 1'b0, 1'b0);
        p_def = 16'h0005;
        p_win = 16'h0014;
        p_big = 16'h5555;
        adv("p6", 16'h0006, 16'h0010, 1'b1, 16'hAAAA, 1'b0);

        // Reset one clock after done is sampled: the in-flight edge must be discarded.
        @(negedge clock);
        done = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        done  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        chk_state("mid_reset", 16'h0000, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0);
        p_def = 16'h0000;
        p_win = 16'h0010;
        p_big = 16'h0000;
        adv("r1", 16'h0001, 16'h0012, 1'b0, 16'h5555, 1'b0);
        adv("r2", 16'h0002, 16'h0014, 1'b0, 16'hAAAA, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
